// File: rtl/apb_master_bridge.sv
// Single-outstanding APB master: core valid/ready requests -> APB SETUP/ACCESS.
// Optional ACCESS-phase timeout is compiled in with `define APB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | req_ready=1, waiting for a core request
// SETUP  | PSEL[idx]=1, PENABLE=0 for one cycle
// ACCESS | PSEL[idx]=1, PENABLE=1 until PREADY[idx] (or timeout)
// RESP   | rsp_valid strobe for one cycle, APB bus idle

module apb_master_bridge #(
  parameter int          NUM_SLAVES     = 4,
  parameter logic [31:0] BASE_ADDR      = 32'h8000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  input  logic                     req_write,
  input  logic [31:0]              req_wdata,
  output logic                     rsp_valid,
  output logic [31:0]              rsp_rdata,
  output logic                     rsp_err,
  output logic [31:0]              PADDR,
  output logic [31:0]              PWDATA,
  output logic                     PWRITE,
  output logic [NUM_SLAVES-1:0]    PSEL,
  output logic                     PENABLE,
  input  logic [NUM_SLAVES*32-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]    PREADY,
  input  logic [NUM_SLAVES-1:0]    PSLVERR
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  idx;
  logic        addr_hit;
  logic [31:0] sel_rdata;
  logic        sel_ready;
  logic        sel_err;
  logic        timeout_hit;

  always_comb begin
    addr_hit = (req_addr[31:14] == BASE_ADDR[31:14]) &&
               (int'(req_addr[13:12]) < NUM_SLAVES);
  end

  // Return-path mux for the latched slave index.
  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx == 2'(i)) begin
        sel_rdata = PRDATA[i*32 +: 32];
        sel_ready = PREADY[i];
        sel_err   = PSLVERR[i];
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;

  // Held at zero outside ACCESS, so it is always clear on entry.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wait_cnt <= '0;
    end else if (state != ACCESS) begin
      wait_cnt <= '0;
    end else if (!sel_ready && (wait_cnt != CNT_W'(TIMEOUT_CYCLES))) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timeout_hit = (state == ACCESS) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_next = addr_hit ? SETUP : RESP;
        end
      end
      SETUP:  state_next = ACCESS;
      ACCESS: begin
        if (sel_ready || timeout_hit) begin
          state_next = RESP;
        end
      end
      RESP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state     <= IDLE;
      idx       <= '0;
      PADDR     <= '0;
      PWDATA    <= '0;
      PWRITE    <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (req_valid) begin
            PADDR  <= req_addr;
            PWRITE <= req_write;
            PWDATA <= req_wdata;
            idx    <= req_addr[13:12];
            if (!addr_hit) begin
              rsp_rdata <= '0;
              rsp_err   <= 1'b1;
            end
          end
        end
        ACCESS: begin
          // PREADY wins over a timeout landing on the same cycle.
          if (sel_ready) begin
            rsp_rdata <= PWRITE ? 32'h0 : sel_rdata;
            rsp_err   <= sel_err;
          end else if (timeout_hit) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign PENABLE   = (state == ACCESS);

  always_comb begin
    PSEL = '0;
    if ((state == SETUP) || (state == ACCESS)) begin
      for (int i = 0; i < NUM_SLAVES; i++) begin
        PSEL[i] = (idx == 2'(i));
      end
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: randomized requests, behavioural slave
// model, expected responses queued at issue and checked by an independent monitor.

module tb_apb_master_bridge;

  localparam int          NS   = 4;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          TO   = 16;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_addr;
  logic              req_write;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [31:0]       PADDR;
  logic [31:0]       PWDATA;
  logic              PWRITE;
  logic [NS-1:0]     PSEL;
  logic              PENABLE;
  logic [NS*32-1:0]  PRDATA;
  logic [NS-1:0]     PREADY;
  logic [NS-1:0]     PSLVERR;

  apb_master_bridge #(
    .NUM_SLAVES(NS),
    .BASE_ADDR(BASE),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .n_rst(n_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
    .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          at;
  } exp_t;
  exp_t exp_q[$];

  // Transaction currently owned by the bus (model view)
  logic        cur_hit   = 1'b0;
  logic [1:0]  cur_idx   = 2'd0;
  logic [31:0] cur_addr  = '0;
  logic [31:0] cur_wdata = '0;
  logic        cur_write = 1'b0;
  int          cur_wait  = 0;
  logic        cur_err   = 1'b0;
  logic [31:0] cur_rdata = '0;
  int          cur_t     = -100;

  logic        have_hold = 1'b0;
  logic [31:0] hold_rdata;
  logic        hold_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: wait bound expired, got no event, required one (cycle %0d)", name, cyc);
  endtask

  // Slave model: target slave stalls cur_wait ACCESS cycles; all other lanes random.
  int acc_cnt = 0;
  always @(negedge clk) begin
    logic rdy;
    for (int i = 0; i < NS; i++) begin
      PREADY[i]          = 1'($urandom);
      PSLVERR[i]         = 1'($urandom);
      PRDATA[i*32 +: 32] = $urandom;
    end
    if (PENABLE && PSEL[cur_idx]) begin
      rdy              = (acc_cnt >= cur_wait);
      PREADY[cur_idx]  = rdy;
      if (rdy) begin
        PSLVERR[cur_idx]         = cur_err;
        PRDATA[cur_idx*32 +: 32] = cur_rdata;
      end
      acc_cnt++;
    end else begin
      acc_cnt = 0;
    end
  end

  // Monitor: response scoreboard plus APB bus checks.
  always @(negedge clk) begin
    exp_t e;
    logic [NS-1:0] exp_sel;
    exp_sel = cur_hit ? (NS'(1) << cur_idx) : '0;
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp_valid", 32'(rsp_valid), 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", 32'(rsp_err), 32'(e.err));
        check("rsp_cycle", cyc, e.at);
        have_hold  = 1'b1;
        hold_rdata = e.rdata;
        hold_err   = e.err;
      end
    end else begin
      if (exp_q.size() > 0 && cyc > exp_q[0].at) begin
        bound_fail("rsp_missing");
        void'(exp_q.pop_front());
      end
      if (have_hold) begin
        check("rsp_rdata_hold", rsp_rdata, hold_rdata);
        check("rsp_err_hold", 32'(rsp_err), 32'(hold_err));
      end
    end
    if (cur_hit && cyc == cur_t + 1) begin
      check("setup_psel", 32'(PSEL), 32'(exp_sel));
      check("setup_penable", 32'(PENABLE), 32'h0);
    end
    if (cur_hit && cyc == cur_t + 2) begin
      check("access_penable", 32'(PENABLE), 32'h1);
    end
    if (PSEL != '0 || PENABLE) begin
      check("psel", 32'(PSEL), 32'(exp_sel));
      check("paddr", PADDR, cur_addr);
      check("pwdata", PWDATA, cur_wdata);
      check("pwrite", 32'(PWRITE), 32'(cur_write));
    end
  end

  task automatic do_req(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                        input int wt, input logic er, input logic [31:0] rd);
    int   n;
    bit   hit;
    bit   tmo;
    int   lat;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      bound_fail("req_ready_wait");
      return;
    end
    hit = ((addr >> 14) == (BASE >> 14)) && (int'((addr >> 12) & 32'h3) < NS);
`ifdef APB_TIMEOUT_EN
    tmo = hit && (wt > TO);
`else
    tmo = 1'b0;
`endif
    lat = !hit ? 1 : (tmo ? 3 + TO : 3 + wt);
    cur_hit   = hit;
    cur_idx   = addr[13:12];
    cur_addr  = addr;
    cur_wdata = wd;
    cur_write = wr;
    cur_wait  = wt;
    cur_err   = er;
    cur_rdata = rd;
    cur_t     = cyc;
    if (lat < 300) begin
      e.rdata = (!hit || wr || tmo) ? 32'h0 : rd;
      e.err   = !hit || tmo || er;
      e.at    = cyc + lat;
      exp_q.push_back(e);
    end
    req_valid = 1'b1;
    req_addr  = addr;
    req_write = wr;
    req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_write = 1'($urandom);
    req_wdata = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) bound_fail("drain");
  endtask

  initial begin
    logic [31:0] a;
    n_rst     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_write = 1'b0;
    req_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'h1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'h0);
    check("rst_paddr", PADDR, 32'h0);
    check("rst_pwdata", PWDATA, 32'h0);
    check("rst_pwrite", 32'(PWRITE), 32'h0);
    check("rst_psel", 32'(PSEL), 32'h0);
    check("rst_penable", 32'(PENABLE), 32'h0);
    n_rst = 1'b1;

    do_req(32'h8000_1008, 1'b0, 32'h0, 0, 1'b0, 32'hDEAD_BEEF);
    do_req(32'h8000_2000, 1'b1, 32'h55, 3, 1'b0, $urandom);
    do_req(32'h4000_0000, 1'b0, 32'h0, 0, 1'b0, $urandom);
    do_req(32'h8000_3004, 1'b0, 32'h0, 1, 1'b1, 32'h1234_5678);
    do_req(32'h8000_3FFC, 1'b0, 32'h0, 2, 1'b0, 32'hCAFE_F00D);
    do_req(32'h8000_4000, 1'b0, 32'h0, 0, 1'b0, $urandom);
    do_req(32'h7FFF_FFFC, 1'b1, 32'hFFFF_0000, 0, 1'b0, $urandom);
    do_req(32'h8000_0000, 1'b1, 32'h0BAD_0001, 0, 1'b1, $urandom);
    do_req(32'h8000_1100, 1'b0, 32'h0, TO, 1'b0, 32'h0000_0F0F);
    do_req(32'h8000_2200, 1'b0, 32'h0, TO + 1, 1'b0, 32'h0000_F0F0);

    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 4) != 0)
        a = {BASE[31:14], 2'($urandom_range(0, 3)), 12'($urandom)};
      else
        a = $urandom;
      do_req(a, 1'($urandom), $urandom, int'($urandom_range(0, 4)),
             ($urandom_range(0, 3) == 0), $urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain();

    // Reset while slave 0 is stalled in ACCESS
    do_req(32'h8000_0010, 1'b0, 32'h0, 1000, 1'b0, 32'hA5A5_A5A5);
    repeat (6) @(negedge clk);
    check("stall_penable", 32'(PENABLE), 32'h1);
    n_rst = 1'b0;
    exp_q.delete();
    have_hold = 1'b0;
    @(negedge clk);
    check("midrst_psel", 32'(PSEL), 32'h0);
    check("midrst_penable", 32'(PENABLE), 32'h0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("midrst_req_ready", 32'(req_ready), 32'h1);
    check("midrst_paddr", PADDR, 32'h0);
    cur_hit = 1'b0;
    n_rst = 1'b1;
    repeat (5) @(negedge clk);
    check("postrst_req_ready", 32'(req_ready), 32'h1);

    // Slave never ready
    do_req(32'h8000_2100, 1'b0, 32'h0, 1000, 1'b0, $urandom);
`ifdef APB_TIMEOUT_EN
    drain();
    check("post_timeout_penable", 32'(PENABLE), 32'h0);
`else
    repeat (100) @(negedge clk);
    check("no_timeout_penable", 32'(PENABLE), 32'h1);
    check("no_timeout_psel", 32'(PSEL), 32'h4);
    n_rst = 1'b0;
    have_hold = 1'b0;
    @(negedge clk);
    cur_hit = 1'b0;
    n_rst = 1'b1;
`endif
    do_req(32'h8000_1000, 1'b0, 32'h0, 0, 1'b0, 32'h600D_600D);
    drain();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
